// File: rtl/tbird_pkg.sv
// Shared state encodings and lamp patterns for the Thunderbird tail-light sequencer.
// Lamp vector layout is {LC,LB,LA,RA,RB,RC}, so each side lights outward from the centre.
package tbird_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_LR3  = 3'd7
  } state_e;

  localparam logic [5:0] PAT_OFF = 6'b000000;
  localparam logic [5:0] PAT_L1  = 6'b001000;
  localparam logic [5:0] PAT_L2  = 6'b011000;
  localparam logic [5:0] PAT_L3  = 6'b111000;
  localparam logic [5:0] PAT_R1  = 6'b000100;
  localparam logic [5:0] PAT_R2  = 6'b000110;
  localparam logic [5:0] PAT_R3  = 6'b000111;
  localparam logic [5:0] PAT_ALL = 6'b111111;

  function automatic logic [5:0] state_pattern(input state_e s);
    logic [5:0] pat;
    pat = PAT_OFF;
    case (s)
      S_IDLE:  pat = PAT_OFF;
      S_L1:    pat = PAT_L1;
      S_L2:    pat = PAT_L2;
      S_L3:    pat = PAT_L3;
      S_R1:    pat = PAT_R1;
      S_R2:    pat = PAT_R2;
      S_R3:    pat = PAT_R3;
      S_LR3:   pat = PAT_ALL;
      default: pat = PAT_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// N-flop single-bit synchroniser for an asynchronous switch input.
// Synchronous reset clears every stage so no stale switch level survives a reset.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {N{1'b0}};
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/thunderbird_tail_fsm.sv
// Thunderbird tail-light sequencer: steps on the clk_div strobe, drives six lamps.
// Lamps and busy are registered from the next state, so they change on the stepping edge.
module thunderbird_tail_fsm
  import tbird_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [5:0] lights,
  output logic       busy
);

  logic       l_s;
  logic       r_s;
  logic       h_s;
  state_e     state_q;
  state_e     state_d;
  logic [5:0] lights_q;
  logic       busy_q;

  sync_nff #(.N(SYNC_STAGES)) u_sync_left (
    .clk (clk),
    .rst (rst),
    .d   (left),
    .q   (l_s)
  );

  sync_nff #(.N(SYNC_STAGES)) u_sync_right (
    .clk (clk),
    .rst (rst),
    .d   (right),
    .q   (r_s)
  );

  sync_nff #(.N(SYNC_STAGES)) u_sync_hazard (
    .clk (clk),
    .rst (rst),
    .d   (hazard),
    .q   (h_s)
  );

  // L3/R3 ignore hazard and fall to IDLE; hazard is picked up on the following strobe.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (h_s || (l_s && r_s)) begin
          state_d = S_LR3;
        end else if (l_s) begin
          state_d = S_L1;
        end else if (r_s) begin
          state_d = S_R1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_L1:    state_d = h_s ? S_LR3 : S_L2;
      S_L2:    state_d = h_s ? S_LR3 : S_L3;
      S_L3:    state_d = S_IDLE;
      S_R1:    state_d = h_s ? S_LR3 : S_R2;
      S_R2:    state_d = h_s ? S_LR3 : S_R3;
      S_R3:    state_d = S_IDLE;
      S_LR3:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lights_q <= PAT_OFF;
      busy_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      lights_q <= state_pattern(state_d);
      busy_q   <= (state_d != S_IDLE);
    end else begin
      state_q  <= state_q;
      lights_q <= lights_q;
      busy_q   <= busy_q;
    end
  end

  assign lights = lights_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_thunderbird_tail_fsm.sv
// Directed, table-driven bench for the Thunderbird tail-light sequencer.
module tb_thunderbird_tail_fsm;

  typedef struct {
    logic       l;
    logic       r;
    logic       h;
    logic [5:0] exp_lights;
    logic       exp_busy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       left;
  logic       right;
  logic       hazard;
  logic [5:0] lights;
  logic       busy;

  int n_cmp;
  int n_bad;
  vec_t vecs[$];

  thunderbird_tail_fsm #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .lights (lights),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic en);
    clk_en = en;
    @(negedge clk);
  endtask

  // three idle clocks then one strobe clock; returns on the negedge after the strobe edge
  task automatic strobe();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [5:0] exp_l, input logic exp_b);
    chk({name, ".lights"}, lights, exp_l);
    chk({name, ".busy"}, {5'b00000, busy}, {5'b00000, exp_b});
  endtask

  task automatic add(input logic l, input logic r, input logic h, input logic [5:0] el);
    vec_t v;
    v.l = l;
    v.r = r;
    v.h = h;
    v.exp_lights = el;
    v.exp_busy = (el != 6'b000000);
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    clk_en = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
    @(negedge clk);

    // reset with left held and strobes pulsing
    left = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    chk_out("reset_hold", 6'b000000, 1'b0);
    rst = 1'b0;
    strobe();
    chk_out("first_after_reset", 6'b001000, 1'b1);

    // held left twice round, then release
    for (int k = 0; k < 2; k++) begin
      add(1'b1, 1'b0, 1'b0, 6'b001000);
      add(1'b1, 1'b0, 1'b0, 6'b011000);
      add(1'b1, 1'b0, 1'b0, 6'b111000);
      add(1'b1, 1'b0, 1'b0, 6'b000000);
    end
    add(1'b0, 1'b0, 1'b0, 6'b000000);
    // both turn switches from IDLE behave like hazard
    add(1'b1, 1'b1, 1'b0, 6'b111111);
    add(1'b1, 1'b1, 1'b0, 6'b000000);
    add(1'b1, 1'b1, 1'b0, 6'b111111);
    add(1'b0, 1'b0, 1'b0, 6'b000000);
    // hazard raised in L2 preempts
    add(1'b1, 1'b0, 1'b0, 6'b001000);
    add(1'b1, 1'b0, 1'b0, 6'b011000);
    add(1'b1, 1'b0, 1'b1, 6'b111111);
    add(1'b1, 1'b0, 1'b1, 6'b000000);
    add(1'b1, 1'b0, 1'b1, 6'b111111);
    add(1'b1, 1'b0, 1'b1, 6'b000000);
    add(1'b0, 1'b0, 1'b0, 6'b000000);
    // hazard in L3 goes to IDLE first
    add(1'b1, 1'b0, 1'b0, 6'b001000);
    add(1'b1, 1'b0, 1'b0, 6'b011000);
    add(1'b1, 1'b0, 1'b0, 6'b111000);
    add(1'b0, 1'b0, 1'b1, 6'b000000);
    add(1'b0, 1'b0, 1'b1, 6'b111111);
    add(1'b0, 1'b0, 1'b0, 6'b000000);
    // hazard in R1 preempts
    add(1'b0, 1'b1, 1'b0, 6'b000100);
    add(1'b0, 1'b1, 1'b1, 6'b111111);
    add(1'b0, 1'b0, 1'b0, 6'b000000);

    left = 1'b0;
    right = 1'b0;
    hazard = 1'b0;
    do_reset();
    left = 1'b1;
    foreach (vecs[i]) begin
      left   = vecs[i].l;
      right  = vecs[i].r;
      hazard = vecs[i].h;
      strobe();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_lights, vecs[i].exp_busy);
    end

    // 3-clock right pulse, then a left request that must wait for IDLE
    left = 1'b0;
    right = 1'b0;
    hazard = 1'b0;
    do_reset();
    right = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    right = 1'b0;
    cyc(1'b1);
    chk_out("rpulse_r1", 6'b000100, 1'b1);
    left = 1'b1;
    strobe();
    chk_out("rpulse_r2", 6'b000110, 1'b1);
    strobe();
    chk_out("rpulse_r3", 6'b000111, 1'b1);
    strobe();
    chk_out("rpulse_idle", 6'b000000, 1'b0);
    strobe();
    chk_out("left_after_r", 6'b001000, 1'b1);

    // strobe frozen for 50 clocks: nothing moves
    for (int c = 0; c < 50; c++) begin
      cyc(1'b0);
      chk_out("frozen", 6'b001000, 1'b1);
    end
    strobe();
    chk_out("thaw_l2", 6'b011000, 1'b1);
    strobe();
    chk_out("thaw_l3", 6'b111000, 1'b1);

    // reset mid-L3 wins over a coincident strobe
    rst = 1'b1;
    cyc(1'b1);
    chk_out("reset_mid_l3", 6'b000000, 1'b0);
    rst = 1'b0;
    left = 1'b0;
    strobe();
    chk_out("idle_after_reset", 6'b000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
